// File: rtl/prover_shuffle_early_ctrl.sv
// Sequencer for the early-round beta shuffle network. It steps the shuffle through every layer,
// starting from a restart at layer 0. After each layer settles it launches all evaluator lanes
// together and collects their completions. A one-cycle done_pulse marks the end of the round.
module prover_shuffle_early_ctrl #(
  parameter int nValBits = 3,
  parameter int nParBits = 1,
  localparam int nValBitsPer = nValBits - nParBits,
  localparam int nValsPer    = 1 << nValBitsPer,
  localparam int nParallel   = 1 << nParBits,
  localparam int nLayers     = nValBitsPer + 1
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   start,
  output logic                   busy,
  output logic                   done_pulse,
  output logic                   shuf_en,
  output logic                   shuf_restart,
  input  logic                   shuf_ready_pulse,
  output logic [nValBitsPer:0]   layer,
  output logic [nValBitsPer:0]   eval_count,
  output logic [nParallel-1:0]   eval_go,
  input  logic [nParallel-1:0]   eval_done
);

  localparam int LW = nValBitsPer + 1;
  localparam logic [LW-1:0] LastLayer = LW'(nLayers - 1);
  localparam logic [LW-1:0] ValsPer   = LW'(nValsPer);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StArm      = 3'd1;
  localparam logic [2:0] StShuf     = 3'd2;
  localparam logic [2:0] StShufWait = 3'd3;
  localparam logic [2:0] StEvalGo   = 3'd4;
  localparam logic [2:0] StEvalWait = 3'd5;
  localparam logic [2:0] StNext     = 3'd6;

  if (nParBits < 1) begin : g_bad_par
    $error("prover_shuffle_early_ctrl: nParBits must be at least 1");
  end
  if (nValBits <= nParBits) begin : g_bad_val
    $error("prover_shuffle_early_ctrl: nValBits must exceed nParBits");
  end

  logic [2:0]           state_q, state_d;
  logic [LW-1:0]        layer_d, eval_count_d;
  logic                 shuf_en_d, shuf_restart_d, done_pulse_d;
  logic [nParallel-1:0] eval_go_d, sticky_q, sticky_d;

  // Next-state and next-output decode; outputs are computed for the state being entered so
  // that every port comes straight from a flop.
  always_comb begin
    state_d        = state_q;
    layer_d        = layer;
    eval_count_d   = eval_count;
    shuf_en_d      = shuf_en;
    shuf_restart_d = 1'b0;
    eval_go_d      = '0;
    done_pulse_d   = 1'b0;
    sticky_d       = sticky_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          layer_d   = '0;
          shuf_en_d = 1'b0;
          state_d   = StArm;
        end
      end
      StArm: begin
        // en has been low for a full cycle, so this rising edge is seen by the shuffle
        shuf_en_d      = 1'b1;
        shuf_restart_d = (layer_d == '0);
        state_d        = StShuf;
      end
      StShuf: begin
        shuf_en_d = 1'b1;
        sticky_d  = '0;
        state_d   = StShufWait;
      end
      StShufWait: begin
        if (shuf_ready_pulse) begin
          eval_go_d    = '1;
          shuf_en_d    = 1'b0;
          eval_count_d = ValsPer >> layer;
          state_d      = StEvalGo;
        end
      end
      StEvalGo: begin
        state_d = StEvalWait;
      end
      StEvalWait: begin
        sticky_d = sticky_q | eval_done;
        if (&sticky_d) state_d = StNext;
      end
      StNext: begin
        if (layer == LastLayer) begin
          done_pulse_d = 1'b1;
          state_d      = StIdle;
        end else begin
          layer_d        = layer + 1'b1;
          shuf_en_d      = 1'b1;
          shuf_restart_d = (layer_d == '0);
          state_d        = StShuf;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; shuf_en resets high to match the shuffle's delayed-en flop.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= StIdle;
      layer        <= '0;
      eval_count   <= ValsPer;
      shuf_en      <= 1'b1;
      shuf_restart <= 1'b0;
      eval_go      <= '0;
      done_pulse   <= 1'b0;
      busy         <= 1'b0;
      sticky_q     <= '0;
    end else begin
      state_q      <= state_d;
      layer        <= layer_d;
      eval_count   <= eval_count_d;
      shuf_en      <= shuf_en_d;
      shuf_restart <= shuf_restart_d;
      eval_go      <= eval_go_d;
      done_pulse   <= done_pulse_d;
      busy         <= (state_d != StIdle);
      sticky_q     <= sticky_d;
    end
  end

endmodule
